// File: rtl/instruction_fetch_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hit, one 4-word line refill per miss (IDLE/MISS/FILL).
// Define ICACHE_STATS_EN to add the HitCount/MissCount outputs.
module instruction_fetch_cache #(
  parameter int WORD_SIZE       = 32,
  parameter int LINE_WORDS      = 4,
  parameter int CACHE_LINE_SIZE = WORD_SIZE * LINE_WORDS,
  parameter int NUM_LINES       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD_SIZE-1:0]       PC,
  input  logic                       ReqValid,
  input  logic                       Flush,
  output logic [WORD_SIZE-1:0]       Instr,
  output logic                       Hit,
  output logic                       Stall,
  output logic                       MemRead,
  output logic [WORD_SIZE-1:0]       MemPC,
  input  logic                       MemReady,
  input  logic [CACHE_LINE_SIZE-1:0] MemLine
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                HitCount,
  output logic [31:0]                MissCount
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

  state_t                     r_state;
  logic [CACHE_LINE_SIZE-1:0] r_data [NUM_LINES];
  logic [TAG_W-1:0]           r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0]       r_valid;
  logic                       r_mem_read;
  logic [WORD_SIZE-1:0]       r_mem_pc;
`ifdef ICACHE_STATS_EN
  logic [31:0]                r_hit_cnt;
  logic [31:0]                r_miss_cnt;
`endif

  logic [IDX_W-1:0]           w_idx;
  logic [IDX_W-1:0]           w_fill_idx;
  logic [TAG_W-1:0]           w_tag;
  logic [TAG_W-1:0]           w_fill_tag;
  logic [1:0]                 w_off;
  logic [CACHE_LINE_SIZE-1:0] w_line;
  logic [WORD_SIZE-1:0]       w_word;
  logic [NUM_LINES-1:0]       w_fill_mask;
  logic                       w_hit;

  assign w_idx       = PC[4 +: IDX_W];
  assign w_tag       = PC[WORD_SIZE-1 -: TAG_W];
  assign w_off       = PC[3:2];
  assign w_fill_idx  = r_mem_pc[4 +: IDX_W];
  assign w_fill_tag  = r_mem_pc[WORD_SIZE-1 -: TAG_W];
  assign w_fill_mask = NUM_LINES'(1) << w_fill_idx;
  assign w_line      = r_data[w_idx];

  always_comb begin
    w_word = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (32'(w_off) == i) w_word = w_line[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Gating with rst keeps Hit/Stall low for the whole asynchronous reset window.
  assign w_hit   = rst && (r_state == IDLE) && ReqValid && !Flush &&
                   r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign Hit     = w_hit;
  assign Instr   = w_hit ? w_word : '0;
  assign Stall   = rst && ReqValid && !w_hit;
  assign MemRead = r_mem_read;
  assign MemPC   = r_mem_pc;
`ifdef ICACHE_STATS_EN
  assign HitCount  = r_hit_cnt;
  assign MissCount = r_miss_cnt;
`endif

  // Line data and tag are captured on the edge where MemReady is sampled in MISS.
  always_ff @(posedge clk) begin
    if (r_state == MISS && MemReady) begin
      r_data[w_fill_idx] <= MemLine;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_mem_read <= 1'b0;
      r_mem_pc   <= '0;
`ifdef ICACHE_STATS_EN
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
`endif
    end else begin
`ifdef ICACHE_STATS_EN
      if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
`endif
      case (r_state)
        IDLE: begin
          if (Flush) r_valid <= '0;
          if (ReqValid && !w_hit) begin
            r_mem_pc   <= {PC[WORD_SIZE-1:4], 4'b0000};
            r_mem_read <= 1'b1;
            r_state    <= MISS;
`ifdef ICACHE_STATS_EN
            r_miss_cnt <= r_miss_cnt + 32'd1;
`endif
          end
        end
        MISS: begin
          if (MemReady) begin
            r_valid    <= (Flush ? '0 : r_valid) | w_fill_mask;
            r_mem_read <= 1'b0;
            r_state    <= FILL;
          end else if (Flush) begin
            r_valid <= '0;
          end
        end
        FILL: begin
          // The line being installed survives a Flush in this cycle.
          if (Flush) r_valid <= w_fill_mask;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_cache.sv
// Bench for instruction_fetch_cache: directed vectors, hand sequences and a randomized run against a set-content reference model.
module tb_instruction_fetch_cache;
  localparam int W  = 32;
  localparam int NL = 4;
  localparam int CL = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  PC = '0;
  logic          ReqValid = 1'b0;
  logic          Flush = 1'b0;
  logic          MemReady = 1'b0;
  logic [CL-1:0] MemLine = '0;
  logic [W-1:0]  Instr;
  logic [W-1:0]  MemPC;
  logic          Hit;
  logic          Stall;
  logic          MemRead;
`ifdef ICACHE_STATS_EN
  logic [31:0]   HitCount;
  logic [31:0]   MissCount;
`endif

  instruction_fetch_cache #(.WORD_SIZE(W), .LINE_WORDS(4), .CACHE_LINE_SIZE(CL), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .PC(PC), .ReqValid(ReqValid), .Flush(Flush),
    .Instr(Instr), .Hit(Hit), .Stall(Stall), .MemRead(MemRead), .MemPC(MemPC),
    .MemReady(MemReady), .MemLine(MemLine)
`ifdef ICACHE_STATS_EN
    , .HitCount(HitCount), .MissCount(MissCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Backing memory: 256 words covering byte addresses 0x000-0x3FF.
  logic [W-1:0] mem [256];
  int  mem_lat = 2;
  int  lat_cnt = 0;
  bit  spur_en = 1'b0;

  // Reference model: what each set holds, plus whether a refill is outstanding.
  bit [NL-1:0]  mv;
  logic [27:0]  mline [NL];
  bit           in_rst = 1'b1;
  bit           m_busy, m_fill;
  logic [W-1:0] m_addr;
  int unsigned  m_hits, m_misses;

  typedef struct {
    logic [W-1:0] pc;
    logic         rv;
    logic         fl;
    logic         hit;
    logic [W-1:0] instr;
    logic         stall;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [CL-1:0] line_of(input logic [W-1:0] a);
    logic [CL-1:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem[int'(a[9:4])*4 + i];
    return l;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mv = '0; m_busy = 0; m_fill = 0; m_addr = '0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_cycle();
    logic         e_hit, e_stall, e_rd;
    logic [W-1:0] e_instr, e_pc;
    int           idx, fi;
    idx = int'((PC >> 4) % NL);
    fi  = int'((m_addr >> 4) % NL);
    e_hit = 0; e_instr = '0; e_rd = 0; e_pc = m_addr;
    if (!in_rst && !m_busy) begin
      e_hit = ReqValid && !Flush && mv[idx] && (mline[idx] == PC[31:4]);
      if (e_hit) e_instr = mem[int'(PC[9:2])];
    end else if (!in_rst) begin
      e_rd = !m_fill;
    end
    e_stall = !in_rst && ReqValid && !e_hit;
    chk("m_hit", Hit, e_hit);
    chk("m_instr", Instr, e_instr);
    chk("m_stall", Stall, e_stall);
    chk("m_memread", MemRead, e_rd);
    chk("m_mempc", MemPC, e_pc);
`ifdef ICACHE_STATS_EN
    chk("m_hitcount", HitCount, m_hits);
    chk("m_misscount", MissCount, m_misses);
`endif
    if (in_rst) return;
    if (e_hit) m_hits++;
    if (!m_busy) begin
      if (Flush) mv = '0;
      if (ReqValid && !e_hit) begin
        m_busy = 1; m_fill = 0; m_addr = PC & ~32'hF; m_misses++;
      end
    end else if (!m_fill) begin
      if (Flush) mv = '0;
      if (MemReady) begin
        mv[fi] = 1; mline[fi] = m_addr[31:4]; m_fill = 1;
      end
    end else begin
      if (Flush) begin mv = '0; mv[fi] = 1; end
      m_busy = 0; m_fill = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while (Stall && n < 100) begin cycle(); #1; n++; end
    chk("wait_idle_stall", Stall, 1'b0);
  endtask

  task automatic do_reset_pulse();
    rst = 0; in_rst = 1; model_reset();
  endtask

  // Memory responder: after mem_lat cycles of MemRead, one-cycle MemReady with the line;
  // optionally throws spurious MemReady pulses with junk data while no request is open.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        MemReady = 0; lat_cnt = 0;
      end else if (MemReady) begin
        MemReady = 0; lat_cnt = 0;
        MemLine = {$urandom, $urandom, $urandom, $urandom};
      end else if (MemRead) begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin MemReady = 1; MemLine = line_of(MemPC); end
      end else begin
        lat_cnt = 0;
        if (spur_en && $urandom_range(0, 5) == 0) begin
          MemReady = 1; MemLine = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    vecs[0] = '{32'h4, 1, 0, 1, 32'h22, 0};
    vecs[1] = '{32'h8, 1, 0, 1, 32'h33, 0};
    vecs[2] = '{32'hC, 1, 0, 1, 32'h44, 0};
    vecs[3] = '{32'h0, 1, 0, 1, 32'h11, 0};
    vecs[4] = '{32'h0, 0, 0, 0, 32'h0, 0};
    vecs[5] = '{32'h0, 0, 1, 0, 32'h0, 0};
    model_reset();

    // Reset with a request pending: everything must stay quiet.
    ReqValid = 1;
    repeat (3) cycle();
    #1;
    chk("rst_hit", Hit, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_memread", MemRead, 0);
    ReqValid = 0;
    rst = 1; in_rst = 0;

    // Cold miss on 0x0.
    PC = 32'h0; ReqValid = 1; #1;
    chk("cold_stall", Stall, 1);
    chk("cold_hit", Hit, 0);
    cycle();
    chk("cold_memread", MemRead, 1);
    chk("cold_mempc", MemPC, 32'h0);
    for (int n = 0; n < 50 && !MemReady; n++) cycle();
    chk("cold_memready_seen", MemReady, 1);
    cycle();
    chk("fill_memread", MemRead, 0);
    chk("fill_stall", Stall, 1);
    chk("fill_hit", Hit, 0);
    cycle();
    chk("resume_hit", Hit, 1);
    chk("resume_instr", Instr, 32'h11);
    cycle();

    foreach (vecs[i]) begin
      PC = vecs[i].pc; ReqValid = vecs[i].rv; Flush = vecs[i].fl; #1;
      chk($sformatf("vec%0d_hit", i), Hit, vecs[i].hit);
      chk($sformatf("vec%0d_instr", i), Instr, vecs[i].instr);
      chk($sformatf("vec%0d_stall", i), Stall, vecs[i].stall);
      chk($sformatf("vec%0d_memread", i), MemRead, 0);
      cycle();
    end
    Flush = 0;
`ifdef ICACHE_STATS_EN
    chk("stats_hitcount", HitCount, 5);
    chk("stats_misscount", MissCount, 1);
`endif

    // After the flush, line 0 must miss again.
    PC = 32'h0; ReqValid = 1; #1;
    chk("flush_hit", Hit, 0);
    chk("flush_stall", Stall, 1);
    cycle();
    chk("flush_memread", MemRead, 1);
    wait_idle();
    chk("flush_refill_instr", Instr, 32'h11);
    cycle();

    // Conflict eviction: 0x40 shares index 0 with 0x0.
    PC = 32'h40; #1;
    chk("conf_hit", Hit, 0);
    cycle();
    chk("conf_mempc", MemPC, 32'h40);
    wait_idle();
    chk("conf_instr", Instr, mem[16]);
    cycle();
    PC = 32'h0; #1;
    chk("evict_hit", Hit, 0);
    chk("evict_stall", Stall, 1);
    cycle();
    chk("evict_mempc", MemPC, 32'h0);
    wait_idle();
    cycle();

    // Asynchronous reset in the middle of a miss.
    mem_lat = 4;
    PC = 32'h80; #1;
    cycle();
    chk("mid_memread", MemRead, 1);
    #1;
    do_reset_pulse();
    #1;
    chk("mid_rst_memread", MemRead, 0);
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_hit", Hit, 0);
    chk("mid_rst_mempc", MemPC, 0);
    cycle();
    cycle();
    rst = 1; in_rst = 0;
    PC = 32'h0; #1;
    chk("post_rst_hit", Hit, 0);
    chk("post_rst_stall", Stall, 1);
    wait_idle();
    cycle();

    // Randomized traffic with flushes, spurious MemReady, varying latency and occasional resets.
    spur_en = 1;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 3) == 0) PC = 32'($urandom_range(0, 255)) << 2;
      else PC = 32'($urandom_range(0, 47)) << 2;
      ReqValid = ($urandom_range(0, 9) < 8);
      Flush    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) mem_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 299) == 0) begin
        do_reset_pulse();
        cycle();
        rst = 1; in_rst = 0;
      end
      cycle();
    end
    ReqValid = 0; Flush = 0; spur_en = 0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
